// File: rtl/vga_pat_pkg.sv
// Shared definitions for the VGA pattern scheduler: mode and FSM encodings,
// active-area limits and the 10-entry RGB565 palette.
package vga_pat_pkg;

  typedef enum logic [1:0] {
    MODE_BAR   = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } sched_state_e;

  localparam logic [9:0] H_VALID = 10'd640;
  localparam logic [9:0] V_VALID = 10'd480;

  localparam logic [15:0] PAL_WHITE   = 16'hFFFF;
  localparam logic [15:0] PAL_YELLOW  = 16'hFFE0;
  localparam logic [15:0] PAL_CYAN    = 16'h07FF;
  localparam logic [15:0] PAL_GREEN   = 16'h07E0;
  localparam logic [15:0] PAL_MAGENTA = 16'hF81F;
  localparam logic [15:0] PAL_RED     = 16'hF800;
  localparam logic [15:0] PAL_BLUE    = 16'h001F;
  localparam logic [15:0] PAL_BLACK   = 16'h0000;
  localparam logic [15:0] PAL_GREY    = 16'h8410;
  localparam logic [15:0] PAL_ORANGE  = 16'hFC00;

  // Palette lookup; indices above 9 never occur inside the active area.
  function automatic logic [15:0] palette(input logic [3:0] idx);
    logic [15:0] c;
    case (idx)
      4'd0:    c = PAL_WHITE;
      4'd1:    c = PAL_YELLOW;
      4'd2:    c = PAL_CYAN;
      4'd3:    c = PAL_GREEN;
      4'd4:    c = PAL_MAGENTA;
      4'd5:    c = PAL_RED;
      4'd6:    c = PAL_BLUE;
      4'd7:    c = PAL_BLACK;
      4'd8:    c = PAL_GREY;
      4'd9:    c = PAL_ORANGE;
      default: c = PAL_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_pattern_sched_key_debounce.sv
// Push-button front end: 2-flop synchroniser, stability counter and a
// single-cycle press pulse on an accepted release->press transition.
module key_debounce #(
  parameter logic [19:0] DEB_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_press
);

  logic        sync1;
  logic        sync2;
  logic        stable;
  logic [19:0] cnt;

  // Bring the asynchronous button into the pixel clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has held for DEB_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      stable    <= 1'b1;
      key_press <= 1'b0;
    end else begin
      key_press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == DEB_CYCLES - 20'd1) begin
        cnt       <= '0;
        stable    <= sync2;
        key_press <= ~sync2;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end

endmodule

// File: rtl/vga_pattern_sched.sv
// Frame-synchronous test-pattern scheduler feeding the VGA timing controller.
// Pattern changes (key press or auto timer) are applied only on the rising
// edge of vsync so a frame is never torn.
// Optional build macro VGA_PAT_GRID_EN: overlays a white 64-pixel grid.
module vga_pattern_sched
  import vga_pat_pkg::*;
#(
  parameter logic [19:0] DEB_CYCLES      = 20'd500000,
  parameter logic [7:0]  FRAMES_PER_MODE = 8'd120
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic        key_n,
  input  logic        auto_en,
  input  logic        vsync,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [15:0] pix_data,
  output logic [1:0]  mode,
  output logic [7:0]  frame_cnt
);

  sched_state_e state_q, state_d;
  logic [1:0]   mode_d;
  logic [7:0]   frame_cnt_d;
  logic [3:0]   solid_idx, solid_d;
  logic         pend, pend_d;
  logic         advance;
  logic         vsync_q;
  logic         frame_tick;
  logic         key_press;
  logic [15:0]  pat;

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_key (
    .clk      (vga_clk),
    .rst_n    (sys_rst_n),
    .key_n    (key_n),
    .key_press(key_press)
  );

  // vsync edge detector; held high in reset so a vsync already high at
  // release does not produce a spurious frame tick.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) vsync_q <= 1'b1;
    else            vsync_q <= vsync;
  end

  assign frame_tick = vsync & ~vsync_q;

  // Scheduler state registers.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_MANUAL;
      mode      <= 2'd0;
      frame_cnt <= '0;
      solid_idx <= '0;
      pend      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode      <= mode_d;
      frame_cnt <= frame_cnt_d;
      solid_idx <= solid_d;
      pend      <= pend_d;
    end
  end

  // Next-state: at most one mode advance per frame tick; a press arriving on
  // the tick cycle itself is kept pending for the following frame.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode;
    frame_cnt_d = frame_cnt;
    solid_d     = solid_idx;
    pend_d      = pend;
    advance     = 1'b0;
    if (frame_tick) begin
      unique case (state_q)
        ST_MANUAL: begin
          advance = pend;
          if (auto_en) begin
            state_d     = ST_AUTO;
            frame_cnt_d = '0;
          end
        end
        ST_AUTO: begin
          if (!auto_en) begin
            state_d     = ST_MANUAL;
            frame_cnt_d = '0;
            advance     = pend;
          end else if (frame_cnt == FRAMES_PER_MODE - 8'd1 || pend) begin
            advance     = 1'b1;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt + 8'd1;
          end
        end
      endcase
      if (advance) begin
        mode_d  = mode + 2'd1;
        solid_d = '0;
      end else if (mode == MODE_SOLID) begin
        solid_d = (solid_idx == 4'd9) ? 4'd0 : solid_idx + 4'd1;
      end
    end
    if (advance)   pend_d = 1'b0;
    if (key_press) pend_d = 1'b1;
  end

  // Pattern mux for the current pixel; black outside the active area.
  always_comb begin
    pat = '0;
    if (pix_x < H_VALID && pix_y < V_VALID) begin
      case (mode)
        MODE_BAR:   pat = palette(pix_x[9:6]);
        MODE_CHECK: pat = (pix_x[5] ^ pix_y[5]) ? PAL_WHITE : PAL_BLACK;
        MODE_GRAD:  pat = {pix_x[9:5], pix_y[8:3], 5'd0};
        default:    pat = palette(solid_idx);
      endcase
`ifdef VGA_PAT_GRID_EN
      if (pix_x[5:0] == 6'd0 || pix_y[5:0] == 6'd0) pat = PAL_WHITE;
`endif
    end
  end

  // Output register: one cycle from pix_x/pix_y to pix_data.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) pix_data <= '0;
    else            pix_data <= pat;
  end

endmodule

// File: tb/tb_vga_pattern_sched.sv
// Self-checking bench for vga_pattern_sched using short synthetic frames.
module tb_vga_pattern_sched;

  localparam int DEB = 4;
  localparam int FPM = 3;

  logic        vga_clk;
  logic        sys_rst_n;
  logic        key_n;
  logic        auto_en;
  logic        vsync;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [15:0] pix_data;
  logic [1:0]  mode;
  logic [7:0]  frame_cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] pal [0:9] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F,
                             16'hF800, 16'h001F, 16'h0000, 16'h8410, 16'hFC00};

  vga_pattern_sched #(
    .DEB_CYCLES     (20'd4),
    .FRAMES_PER_MODE(8'd3)
  ) dut (
    .vga_clk  (vga_clk),
    .sys_rst_n(sys_rst_n),
    .key_n    (key_n),
    .auto_en  (auto_en),
    .vsync    (vsync),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .pix_data (pix_data),
    .mode     (mode),
    .frame_cnt(frame_cnt)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference pixel from pattern rules expressed in plain arithmetic.
  function automatic logic [15:0] ref_pix(int m, int s, int x, int y);
    logic [4:0] r;
    logic [5:0] g;
    if (x >= 640 || y >= 480) return 16'h0000;
`ifdef VGA_PAT_GRID_EN
    if (x % 64 == 0 || y % 64 == 0) return 16'hFFFF;
`endif
    case (m)
      0: return pal[x / 64];
      1: return (((x / 32) + (y / 32)) % 2 == 1) ? 16'hFFFF : 16'h0000;
      2: begin
        r = 5'(x / 32);
        g = 6'(y / 8);
        return {r, g, 5'd0};
      end
      default: return pal[s];
    endcase
  endfunction

  // Behavioural model state.
  int          m_mode, m_fc, m_solid, m_run;
  bit          m_pend, m_auto, m_vs, m_stable;
  logic [15:0] m_pix;

  // Model update: key accepted after DEB consecutive samples at a new level;
  // frame rules applied on each vsync rise.
  always @(posedge vga_clk or negedge sys_rst_n) begin : model_blk
    bit tick, press, adv, stable_n, auto_n, pend_n;
    int run_n, fc_n, mode_n, solid_n;
    if (!sys_rst_n) begin
      m_mode <= 0; m_fc <= 0; m_solid <= 0; m_run <= 0;
      m_pend <= 0; m_auto <= 0; m_vs <= 1; m_stable <= 1; m_pix <= 16'h0000;
    end else begin
      tick = vsync && !m_vs;
      press = 0; stable_n = m_stable; run_n = m_run;
      if (key_n == m_stable) run_n = 0;
      else begin
        run_n = m_run + 1;
        if (run_n == DEB) begin
          stable_n = key_n; run_n = 0; press = !key_n;
        end
      end
      adv = 0; auto_n = m_auto; fc_n = m_fc; mode_n = m_mode;
      solid_n = m_solid; pend_n = m_pend;
      if (tick) begin
        if (!m_auto) begin
          adv = m_pend;
          if (auto_en) begin auto_n = 1; fc_n = 0; end
        end else if (!auto_en) begin
          auto_n = 0; fc_n = 0; adv = m_pend;
        end else if (m_fc == FPM - 1 || m_pend) begin
          adv = 1; fc_n = 0;
        end else fc_n = m_fc + 1;
        if (adv) begin mode_n = (m_mode + 1) % 4; solid_n = 0; pend_n = 0; end
        else if (m_mode == 3) solid_n = (m_solid + 1) % 10;
      end
      if (press) pend_n = 1;
      m_pix    <= ref_pix(m_mode, m_solid, int'(pix_x), int'(pix_y));
      m_stable <= stable_n; m_run <= run_n; m_vs <= vsync;
      m_auto <= auto_n; m_fc <= fc_n; m_mode <= mode_n;
      m_solid <= solid_n; m_pend <= pend_n;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge vga_clk) begin
    if (sys_rst_n) begin
      check("pix_data", pix_data, m_pix);
      check("mode", mode, m_mode);
      check("frame_cnt", frame_cnt, m_fc);
    end
  end

  task automatic do_reset();
    @(negedge vga_clk);
    key_n = 1'b1; vsync = 1'b0; sys_rst_n = 1'b0;
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
  endtask

  // One synthetic frame: vsync high for 2 cycles, random pixels, up to two key lows.
  task automatic run_frame(int len, int ks, int kl, int ks2, int kl2);
    for (int c = 0; c < len; c++) begin
      @(negedge vga_clk);
      vsync = (c < 2);
      key_n = !((c >= ks && c < ks + kl) || (c >= ks2 && c < ks2 + kl2));
      pix_x = 10'($urandom_range(0, 700));
      pix_y = 10'($urandom_range(0, 520));
    end
  endtask

  task automatic probe(string name, int x, int y, logic [15:0] exp);
    @(negedge vga_clk);
    vsync = 1'b0; key_n = 1'b1; pix_x = 10'(x); pix_y = 10'(y);
    @(negedge vga_clk);
    check(name, pix_data, exp);
  endtask

  int exp_m [15] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0};
  int exp_f [15] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2};

  initial begin
    int len, sc, ks, kl, ks2, kl2;
    sys_rst_n = 1'b0; key_n = 1'b1; auto_en = 1'b0; vsync = 1'b0;
    pix_x = '0; pix_y = '0;
    repeat (3) @(negedge vga_clk);
    check("rst_pix", pix_data, 16'h0000);
    check("rst_mode", mode, 2'd0);
    check("rst_fc", frame_cnt, 8'd0);
    sys_rst_n = 1'b1;

    // Colour-bar sweep at y=100.
    for (int c = 0; c < 643; c++) begin
      @(negedge vga_clk);
      if (c >= 1) begin
        case (c - 1)
          0:   check("bar_x0", pix_data, 16'hFFFF);
          65:  check("bar_x65", pix_data, 16'hFFE0);
          639: check("bar_x639", pix_data, 16'hFC00);
          640: check("bar_x640", pix_data, 16'h0000);
          default: ;
        endcase
      end
      vsync = (c < 2); key_n = 1'b1; pix_x = 10'(c); pix_y = 10'd100;
    end

    // Manual press: takes effect at the next vsync rise only.
    run_frame(50, 20, 10, 0, 0);
    check("man_hold", mode, 2'd0);
    run_frame(40, 0, 0, 0, 0);
    check("man_adv", mode, 2'd1);
    probe("chk_32_0", 32, 0, 16'hFFFF);
    probe("chk_32_32", 32, 32, 16'h0000);
`ifdef VGA_PAT_GRID_EN
    probe("grid_64_7", 64, 7, 16'hFFFF);
`endif
    // Bounce shorter than the debounce time.
    run_frame(50, 20, 2, 0, 0);
    run_frame(40, 0, 0, 0, 0);
    check("bounce", mode, 2'd1);
    // Two valid presses in one frame give one advance.
    run_frame(70, 10, 6, 30, 6);
    run_frame(40, 0, 0, 0, 0);
    check("two_press", mode, 2'd2);
    run_frame(40, 0, 0, 0, 0);
    check("two_press_hold", mode, 2'd2);

    // Solid cycle over 12 frames, then leave and return.
    do_reset();
    repeat (3) run_frame(50, 10, 6, 0, 0);
    for (int k = 0; k < 12; k++) begin
      run_frame(40, 0, 0, 0, 0);
      probe($sformatf("solid_%0d", k), 100, 100, pal[k % 10]);
    end
    repeat (4) run_frame(50, 10, 6, 0, 0);
    run_frame(40, 0, 0, 0, 0);
    check("solid_ret_mode", mode, 2'd3);
    probe("solid_restart", 100, 100, 16'hFFFF);

    // Auto cycling with FRAMES_PER_MODE=3; press on the expiry frame.
    do_reset();
    auto_en = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (k == 14) run_frame(40, 10, 6, 0, 0);
      else         run_frame(40, 0, 0, 0, 0);
      check($sformatf("auto_mode_%0d", k), mode, exp_m[k]);
      check($sformatf("auto_fc_%0d", k), frame_cnt, exp_f[k]);
    end
    run_frame(40, 0, 0, 0, 0);
    check("expiry_mode", mode, 2'd1);
    check("expiry_fc", frame_cnt, 8'd0);
    run_frame(40, 0, 0, 0, 0);
    check("expiry_mode2", mode, 2'd1);
    check("expiry_fc2", frame_cnt, 8'd1);

    // Randomised frames, keys and auto_en.
    for (int i = 0; i < 60; i++) begin
      auto_en = ($urandom_range(0, 3) != 0);
      len = $urandom_range(56, 80);
      sc  = $urandom_range(0, 2);
      ks  = 5 + $urandom_range(0, 10);
      kl  = 1 + $urandom_range(0, 9);
      ks2 = ks + kl + 1 + $urandom_range(0, 7);
      kl2 = 1 + $urandom_range(0, 9);
      if (sc == 0) begin kl = 0; kl2 = 0; end
      if (sc == 1) kl2 = 0;
      run_frame(len, ks, kl, ks2, kl2);
    end

    // Asynchronous reset mid-frame.
    auto_en = 1'b1;
    repeat (4) run_frame(40, 0, 0, 0, 0);
    probe("pre_rst_pix", 100, 100, ref_pix(m_mode, m_solid, 100, 100));
    @(negedge vga_clk);
    key_n = 1'b1; vsync = 1'b0;
    #2 sys_rst_n = 1'b0;
    #1;
    check("mid_rst_pix", pix_data, 16'h0000);
    check("mid_rst_mode", mode, 2'd0);
    check("mid_rst_fc", frame_cnt, 8'd0);
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    run_frame(40, 0, 0, 0, 0);
    check("post_rst_t1", mode, 2'd0);
    run_frame(40, 0, 0, 0, 0);
    check("post_rst_t2_fc", frame_cnt, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
